// File: rtl/snn_conv_scheduler.sv
// rtl/snn_conv_scheduler.sv - sequences 5x5 spiking convolution MAC commands and tags returned pixel results
module snn_conv_scheduler #(
    parameter int IFMAP_DIM  = 25,
    parameter int FILTER_DIM = 5,
    parameter int OUT_DIM    = 21,
    parameter int NUM_TS     = 2,
    parameter int LAYER_ID   = 1,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 13,
    parameter int MAX_OUT    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_done,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [1:0]        cmd_ts,
    output logic [ADDR_W-1:0] cmd_ifmap_addr,
    output logic [ADDR_W-1:0] cmd_filter_addr,
    output logic              cmd_first,
    output logic              cmd_last,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [DATA_W-1:0] res_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_ts,
    output logic [1:0]        out_layer,
    output logic              out_first,
    output logic              start_r,
    output logic              done_r,
    output logic              busy,
    output logic              err
);
    localparam int CW    = $clog2(OUT_DIM);
    localparam int KW    = $clog2(FILTER_DIM);
    localparam int IW    = $clog2(MAX_OUT + 1);
    localparam int TOTAL = NUM_TS * OUT_DIM * OUT_DIM;
    localparam int NW    = $clog2(TOTAL + 1);

    typedef enum logic [2:0] {IDLE, LOADING, ISSUE, DRAIN, DONE} state_e;
    state_e state_q, state_d;

    logic [1:0]    ts_q, ts_d, rts_q, rts_d;
    logic [CW-1:0] r_q, r_d, c_q, c_d, rr_q, rr_d, rc_q, rc_d;
    logic [KW-1:0] kr_q, kr_d, kc_q, kc_d;
    logic [IW-1:0] inflight_q, inflight_d;
    logic [NW-1:0] ocnt_q, ocnt_d;
    logic          out_valid_q, err_q;

    logic tap_first, tap_last, final_pix, credit_full;
    logic cmd_fire, res_fire, out_fire, start_load;

    assign tap_first   = (kr_q == '0) && (kc_q == '0);
    assign tap_last    = (kr_q == KW'(FILTER_DIM - 1)) && (kc_q == KW'(FILTER_DIM - 1));
    assign final_pix   = (r_q == CW'(OUT_DIM - 1)) && (c_q == CW'(OUT_DIM - 1)) && (ts_q == 2'(NUM_TS));
    assign credit_full = (inflight_q == IW'(MAX_OUT));
    assign cmd_fire    = cmd_valid && cmd_ready;
    assign res_ready   = !out_valid_q || out_ready;
    assign res_fire    = res_valid && res_ready && (inflight_q != '0);
    assign out_fire    = out_valid_q && out_ready;
    assign start_load  = (state_q == LOADING) && load_done;

    assign cmd_ts          = ts_q;
    assign cmd_first       = tap_first;
    assign cmd_last        = tap_last;
    assign cmd_ifmap_addr  = (ADDR_W'(r_q) + ADDR_W'(kr_q)) * ADDR_W'(IFMAP_DIM) + ADDR_W'(c_q) + ADDR_W'(kc_q);
    assign cmd_filter_addr = ADDR_W'(kr_q) * ADDR_W'(FILTER_DIM) + ADDR_W'(kc_q);
    assign out_valid       = out_valid_q;
    assign start_r         = out_fire && (ocnt_q == '0);
    assign err             = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_start) state_d = LOADING;
            LOADING: if (load_done) state_d = ISSUE;
            ISSUE:   if (cmd_fire && tap_last && final_pix) state_d = DRAIN;
            DRAIN:   if (ocnt_d == NW'(TOTAL)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Credit only gates the start of a new pixel; a started pixel always completes.
    always_comb begin
        busy      = (state_q != IDLE);
        done_r    = (state_q == DONE);
        cmd_valid = (state_q == ISSUE) && !(tap_first && credit_full);
    end

    always_comb begin
        ts_d  = ts_q;  r_d  = r_q;  c_d  = c_q;  kr_d = kr_q; kc_d = kc_q;
        rts_d = rts_q; rr_d = rr_q; rc_d = rc_q;
        if (start_load) begin
            ts_d  = 2'd1; r_d  = '0; c_d = '0; kr_d = '0; kc_d = '0;
            rts_d = 2'd1; rr_d = '0; rc_d = '0;
        end else begin
            if (cmd_fire && !(tap_last && final_pix)) begin
                if (kc_q != KW'(FILTER_DIM - 1))  kc_d = kc_q + 1'b1;
                else begin
                    kc_d = '0;
                    if (kr_q != KW'(FILTER_DIM - 1)) kr_d = kr_q + 1'b1;
                    else begin
                        kr_d = '0;
                        if (c_q != CW'(OUT_DIM - 1)) c_d = c_q + 1'b1;
                        else begin
                            c_d = '0;
                            if (r_q != CW'(OUT_DIM - 1)) r_d = r_q + 1'b1;
                            else begin
                                r_d  = '0;
                                ts_d = ts_q + 2'd1;
                            end
                        end
                    end
                end
            end
            if (res_fire) begin
                if (rc_q != CW'(OUT_DIM - 1)) rc_d = rc_q + 1'b1;
                else begin
                    rc_d = '0;
                    if (rr_q != CW'(OUT_DIM - 1)) rr_d = rr_q + 1'b1;
                    else begin
                        rr_d  = '0;
                        rts_d = rts_q + 2'd1;
                    end
                end
            end
        end
        inflight_d = inflight_q + IW'(cmd_fire && tap_last) - IW'(res_fire);
        ocnt_d     = start_load ? '0 : ocnt_q + NW'(out_fire);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q <= '0; r_q <= '0; c_q <= '0; kr_q <= '0; kc_q <= '0;
            rts_q <= '0; rr_q <= '0; rc_q <= '0;
            inflight_q <= '0; ocnt_q <= '0; err_q <= 1'b0;
            out_valid_q <= 1'b0; out_addr <= '0; out_data <= '0;
            out_ts <= '0; out_layer <= '0; out_first <= 1'b0;
        end else begin
            ts_q <= ts_d; r_q <= r_d; c_q <= c_d; kr_q <= kr_d; kc_q <= kc_d;
            rts_q <= rts_d; rr_q <= rr_d; rc_q <= rc_d;
            inflight_q <= inflight_d;
            ocnt_q     <= ocnt_d;
            if (res_valid && (inflight_q == '0)) err_q <= 1'b1;
            if (res_fire) begin
                out_valid_q <= 1'b1;
                out_data    <= res_data;
                out_addr    <= ADDR_W'(rr_q) * ADDR_W'(OUT_DIM) + ADDR_W'(rc_q);
                out_ts      <= rts_q;
                out_layer   <= 2'(LAYER_ID);
                out_first   <= (rr_q == '0) && (rc_q == '0);
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_snn_conv_scheduler.sv
// tb/tb_snn_conv_scheduler.sv - randomized self-checking bench for snn_conv_scheduler
module tb_snn_conv_scheduler;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 13;
    localparam int I      = 25;
    localparam int F      = 5;
    localparam int R      = 21;
    localparam int NPIX   = R * R;
    localparam int TAPS   = F * F;
    localparam int NCMD   = 2 * NPIX * TAPS;
    localparam int NOUT   = 2 * NPIX;

    logic clk = 1'b0;
    logic reset, load_start, load_done;
    logic cmd_valid, cmd_ready, cmd_first, cmd_last;
    logic [1:0] cmd_ts;
    logic [ADDR_W-1:0] cmd_ifmap_addr, cmd_filter_addr;
    logic res_valid, res_ready;
    logic [DATA_W-1:0] res_data;
    logic out_valid, out_ready, out_first, start_r, done_r, busy, err;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic [1:0] out_ts, out_layer;

    snn_conv_scheduler dut (
        .clk(clk), .reset(reset), .load_start(load_start), .load_done(load_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ts(cmd_ts),
        .cmd_ifmap_addr(cmd_ifmap_addr), .cmd_filter_addr(cmd_filter_addr),
        .cmd_first(cmd_first), .cmd_last(cmd_last),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .out_ts(out_ts), .out_layer(out_layer),
        .out_first(out_first), .start_r(start_r), .done_r(done_r),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int cmd_pct, out_pct, res_pct;
    bit res_en;
    int ncmd, nout, next_pix, nstart, ndone, start_ok, cyc, done_cyc, last_out_cyc;
    logic last_first;
    int dpq[$];

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Command n decoded straight from the loop nest ts / r / c / kr / kc.
    function automatic logic [27:0] exp_cmd(input int n);
        int ts, p, r, c, t, kr, kc, ifm;
        ts  = n / (NPIX * TAPS) + 1;
        p   = (n / TAPS) % NPIX;
        r   = p / R;
        c   = p % R;
        t   = n % TAPS;
        kr  = t / F;
        kc  = t % F;
        ifm = (r + kr) * I + (c + kc);
        return {2'(ts), 12'(ifm), 12'(t), (t == 0), (t == TAPS - 1)};
    endfunction

    function automatic logic [29:0] exp_out(input int k);
        return {12'(k % NPIX), 13'(k), 2'(k / NPIX + 1), (k % NPIX == 0), 2'd1};
    endfunction

    task automatic clear_model();
        ncmd = 0; nout = 0; next_pix = 0; nstart = 0; ndone = 0; start_ok = 0;
        cyc = 0; done_cyc = -100; last_out_cyc = -100; last_first = 1'b0;
        dpq.delete();
    endtask

    // Entered and left at posedge+1: drive, sample on negedge, advance.
    task automatic tick();
        cmd_ready = ($urandom_range(99) < cmd_pct);
        out_ready = ($urandom_range(99) < out_pct);
        if (res_en && dpq.size() > 0 && $urandom_range(99) < res_pct) begin
            res_valid = 1'b1;
            res_data  = 13'(dpq[0]);
        end else begin
            res_valid = 1'b0;
            res_data  = '0;
        end
        @(negedge clk);
        if (cmd_valid && cmd_ready) begin
            expect_eq("cmd", {cmd_ts, cmd_ifmap_addr, cmd_filter_addr, cmd_first, cmd_last}, exp_cmd(ncmd));
            if (cmd_last) begin
                dpq.push_back(next_pix);
                next_pix++;
            end
            last_first = cmd_first;
            ncmd++;
        end
        if (res_valid && res_ready) dpq.delete(0);
        if (out_valid && out_ready) begin
            expect_eq("out", {out_addr, out_data, out_ts, out_first, out_layer}, exp_out(nout));
            if (nout == 0 && start_r) start_ok = 1;
            nout++;
            if (nout == NOUT) last_out_cyc = cyc;
        end
        if (start_r) nstart++;
        if (done_r) begin
            ndone++;
            done_cyc = cyc;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic start_layer();
        cmd_ready = 1'b0; res_valid = 1'b0; out_ready = 1'b0;
        load_start = 1'b1;
        @(posedge clk); #1 load_start = 1'b0;
        expect_eq("busy_loading", busy, 1'b1);
        @(posedge clk); #1 load_done = 1'b1;
        @(posedge clk); #1 load_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; load_start = 1'b0; load_done = 1'b0;
        cmd_ready = 1'b0; res_valid = 1'b0; res_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_layer(input int cp, input int op, input int rp, input logic exp_err);
        clear_model();
        cmd_pct = cp; out_pct = op; res_pct = rp; res_en = 1'b1;
        start_layer();
        for (int i = 0; i < 60000; i++) begin
            tick();
            if (ndone > 0 && cyc > done_cyc + 2) break;
        end
        expect_eq("layer_done_seen", (ndone > 0), 1'b1);
        expect_eq("cmd_count", ncmd, NCMD);
        expect_eq("out_count", nout, NOUT);
        expect_eq("start_pulses", nstart, 1);
        expect_eq("start_on_first", start_ok, 1);
        expect_eq("done_pulses", ndone, 1);
        expect_eq("done_timing", done_cyc, last_out_cyc + 1);
        expect_eq("busy_after", busy, 1'b0);
        expect_eq("err_after", err, exp_err);
        expect_eq("dp_empty", dpq.size(), 0);
    endtask

    initial begin
        reset = 1'b1; load_start = 1'b0; load_done = 1'b0;
        cmd_ready = 1'b0; res_valid = 1'b0; res_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_eq("rst_busy", busy, 1'b0);
        expect_eq("rst_cmd_valid", cmd_valid, 1'b0);
        expect_eq("rst_out_valid", out_valid, 1'b0);
        expect_eq("rst_cmd_ts", cmd_ts, 2'd0);
        expect_eq("rst_out_layer", out_layer, 2'd0);
        expect_eq("rst_flags", {err, done_r, start_r}, 3'b000);
        reset = 1'b0;
        @(posedge clk); #1;

        // result with nothing in flight
        res_valid = 1'b1; res_data = 13'd7;
        @(negedge clk);
        expect_eq("err_res_ready", res_ready, 1'b1);
        @(posedge clk); #1 res_valid = 1'b0;
        expect_eq("err_set", err, 1'b1);
        expect_eq("err_no_out", out_valid, 1'b0);
        @(posedge clk); #1;
        expect_eq("err_no_out2", out_valid, 1'b0);
        expect_eq("err_sticky", err, 1'b1);

        run_layer(100, 100, 100, 1'b1);

        // credit stall
        do_reset();
        clear_model();
        cmd_pct = 100; out_pct = 100; res_pct = 100; res_en = 1'b0;
        start_layer();
        repeat (150) tick();
        expect_eq("stall_count", ncmd, 100);
        expect_eq("stall_valid", cmd_valid, 1'b0);
        res_en = 1'b1;
        tick();
        res_en = 1'b0;
        for (int i = 0; i < 10 && ncmd < 101; i++) tick();
        expect_eq("release_count", ncmd, 101);
        expect_eq("release_first", last_first, 1'b1);

        // abort mid-issue, then a stray load_done
        reset = 1'b1;
        @(posedge clk); #1;
        expect_eq("abort_state", {busy, cmd_valid, out_valid}, 3'b000);
        reset = 1'b0;
        @(posedge clk); #1 load_done = 1'b1;
        @(posedge clk); #1 load_done = 1'b0;
        @(posedge clk); #1;
        expect_eq("stray_load_done", {busy, cmd_valid}, 2'b00);

        run_layer(50, 50, 70, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/snn_conv_scheduler.md
Name: snn_conv_scheduler

Overview:
Clocked controller that sequences the 5x5 spiking convolution over the 25x25 ifmap for every timestep. It emits one MAC command per (output pixel, kernel tap) to the PE datapath. It collects one membrane/spike result per output pixel and tags it with output address, timestep and layer for the output channel. It also generates the start_r/done_r framing that the output side of the NoC expects.

Parameters:
IFMAP_DIM, 25, ifmap side length (I)
FILTER_DIM, 5, filter side length (F)
OUT_DIM, 21, output side length (R = I-F+1)
NUM_TS, 2, timesteps per layer
LAYER_ID, 1, value driven on out_layer
ADDR_W, 12, address width
DATA_W, 13, result data width
MAX_OUT, 4, maximum output pixels in flight in the datapath

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
load_start  in  1  1-cycle pulse: memory load begins
load_done  in  1  1-cycle pulse: filter + all ifmaps loaded
cmd_valid  out  1  MAC command valid
cmd_ready  in  1  datapath accepts command
cmd_ts  out  2  timestep of command (1..NUM_TS)
cmd_ifmap_addr  out  ADDR_W  ifmap word address
cmd_filter_addr  out  ADDR_W  filter word address
cmd_first  out  1  first tap of pixel (clear accumulator)
cmd_last  out  1  last tap of pixel (threshold and return result)
res_valid  in  1  datapath result valid
res_ready  out  1  scheduler accepts result
res_data  in  DATA_W  result for oldest in-flight pixel
out_valid  out  1  tagged result valid
out_ready  in  1  consumer accepts
out_addr  out  ADDR_W  output pixel index r*R+c
out_data  out  DATA_W  registered res_data
out_ts  out  2  timestep of out_data
out_layer  out  2  LAYER_ID
out_first  out  1  first pixel of a timestep
start_r  out  1  1-cycle pulse: first out transfer of the layer
done_r  out  1  1-cycle pulse: layer complete
busy  out  1  state != IDLE
err  out  1  sticky: result received with zero pixels in flight

Behaviour:
- Reset: state=IDLE; all counters 0; all outputs 0 (cmd_ts=0, out_layer=0). Asserting reset mid-operation aborts immediately; there is no resume.
- States:
  - IDLE -> LOADING on load_start.
  - LOADING -> ISSUE on load_done.
  - ISSUE -> DRAIN when the cmd_last handshake of the final pixel of timestep NUM_TS completes.
  - DRAIN -> DONE when all NUM_TS*R*R out transfers are complete.
  - DONE -> IDLE after 1 cycle. done_r=1 in DONE only.
- load_done outside LOADING is ignored. load_start outside IDLE is ignored.
- Issue order: ts 1..NUM_TS, then r 0..R-1, then c 0..R-1, then kr 0..F-1, then kc 0..F-1 (innermost).
  - cmd_ifmap_addr = (r+kr)*I + (c+kc).
  - cmd_filter_addr = kr*F + kc.
  - cmd_first = (kr==0 && kc==0). cmd_last = (kr==F-1 && kc==F-1).
- Command handshake: a transfer occurs when cmd_valid && cmd_ready. Fields are registered and stay stable while cmd_valid && !cmd_ready. Throughput is one command per cycle.
- Credit counter inflight:
  - +1 on the cmd_last transfer; -1 on the res transfer. Both in the same cycle leaves it unchanged.
  - cmd_valid is deasserted before a cmd_first tap when inflight==MAX_OUT. Taps inside a started pixel are never blocked by credit.
- Result path:
  - One-entry output register. res_ready = !out_valid || out_ready.
  - A res transfer loads out_data and sets out_valid on the next cycle (latency 1). Tags come from a result counter (rr, rc, rts) advancing in issue order.
  - out_first=1 when rr==0 && rc==0.
  - start_r pulses in the cycle of the first out transfer of the layer.
- res_valid while inflight==0: err<=1. The result is dropped, res_ready stays asserted, and counters are unchanged.
- Counter wrap: kc wraps to 0 and increments kr; kr increments c; c increments r; r=R-1 wrap increments ts. The result counter wraps the same way.
- Arithmetic is unsigned. The maximum address, 624, fits in ADDR_W.

Test Plan:
- Reset/idle: assert reset mid-ISSUE -> next cycle busy=0, cmd_valid=0, out_valid=0. A later load_done without load_start -> busy stays 0.
- Address sequencing, cmd_ready=1 always:
  - Command 0: ifmap 0, filter 0, first=1, ts=1.
  - Command 24: ifmap 104, filter 24, last=1.
  - Command 25: ifmap 1, first=1.
  - Last command (#22049): ifmap 624, filter 24, ts=2, last=1.
- Credit stall: res_valid=0, MAX_OUT=4 -> exactly 100 commands issued, then cmd_valid=0. Release one result -> command 100 issues with first=1.
- Backpressure on both channels (random 50% cmd_ready/out_ready, datapath returns res_data=pixel index) -> 882 out transfers total. out_addr runs 0..440 twice, out_ts 1 then 2, out_first on transfers 0 and 441, out_data matches, no drops or duplicates.
- Framing: start_r one pulse coincident with the first out transfer. done_r one pulse one cycle after the 882nd transfer. busy=0 afterwards.
- Protocol error: res_valid before any cmd_last -> err=1 sticky, no out_valid. Normal run afterwards still produces 882 correct outputs.
